// File: rtl/mvu_weight_streamer_if.sv
// AXI-stream weight beat bundle between mvu_weight_streamer and its MVU/VVU consumer.
interface mvu_weight_streamer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mvu_weight_streamer.sv
// mvu_weight_streamer: reads the weight memory in (nf outer, sf inner) order for
// reps images and streams it out over AXI-stream. Read latency is absorbed by a
// credit-limited first-word-fall-through FIFO sized MEM_LATENCY+2, which is just
// deep enough to sustain one beat per cycle.
// Optional: define MVU_WEIGHT_STREAMER_PERF_EN to add stall/starve counters.
module mvu_weight_streamer #(
  parameter int MW           = 16,
  parameter int MH           = 8,
  parameter int PE           = 2,
  parameter int SIMD         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MEM_LATENCY  = 2,
  parameter int REPS_WIDTH   = 16,
  localparam int SF          = MW / SIMD,
  localparam int NF          = MH / PE,
  localparam int DEPTH       = SF * NF,
  localparam int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WW          = PE * SIMD * WEIGHT_WIDTH,
  localparam int WW_BA       = ((WW + 7) / 8) * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REPS_WIDTH-1:0] cfg_reps,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [WW-1:0]         mem_rd_data,
  mvu_weight_streamer_if.master m_axis_weights
`ifdef MVU_WEIGHT_STREAMER_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_starve_cycles
`endif
);

  localparam int FIFO_DEPTH = MEM_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int SF_W       = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_W       = (NF > 1) ? $clog2(NF) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [SF_W-1:0]         sf;
  logic [NF_W-1:0]         nf;
  logic [REPS_WIDTH-1:0]   rep, reps_q;
  logic [CNT_W-1:0]        inflight, fifo_count;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [MEM_LATENCY-1:0]  vld_pipe, last_pipe;
  logic [WW-1:0]           fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic                    zero_done_q;

  logic accept, has_credit, issue, sf_wrap, nf_wrap, rep_wrap, beat_last;
  logic push, pop, fifo_empty, drain_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept      = (state == IDLE) && start && !zero_done_q && (cfg_reps != '0);
  assign has_credit  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign issue       = (state == RUN) && has_credit;
  assign sf_wrap     = (sf == SF_W'(SF - 1));
  assign nf_wrap     = (nf == NF_W'(NF - 1));
  assign rep_wrap    = (rep == reps_q - REPS_WIDTH'(1));
  assign beat_last   = sf_wrap && nf_wrap;
  assign push        = vld_pipe[MEM_LATENCY-1];
  assign fifo_empty  = (fifo_count == '0);
  assign pop         = !fifo_empty && m_axis_weights.tready;
  assign drain_empty = (inflight == '0) && fifo_empty;

  assign mem_rd_en   = issue;
  assign mem_rd_addr = ADDR_W'(int'(nf) * SF + int'(sf));

  assign m_axis_weights.tvalid = !fifo_empty;
  assign m_axis_weights.tdata  = fifo_empty ? '0 : WW_BA'(fifo_data[rd_ptr]);
  assign m_axis_weights.tlast  = !fifo_empty && fifo_last[rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus busy/done; done coincides with the cycle busy drops.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = zero_done_q;
    case (state)
      IDLE:  if (accept) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (issue && beat_last && rep_wrap) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero-image request completes immediately with a lone done pulse.
  always_ff @(posedge clk) begin
    if (rst) zero_done_q <= 1'b0;
    else     zero_done_q <= (state == IDLE) && start && !zero_done_q && (cfg_reps == '0);
  end

  // Address counters: sf inner, nf outer, rep outermost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sf     <= '0;
      nf     <= '0;
      rep    <= '0;
      reps_q <= '0;
    end else if (accept) begin
      sf     <= '0;
      nf     <= '0;
      rep    <= '0;
      reps_q <= cfg_reps;
    end else if (issue) begin
      if (sf_wrap) begin
        sf <= '0;
        if (nf_wrap) begin
          nf  <= '0;
          rep <= rep_wrap ? '0 : rep + 1'b1;
        end else begin
          nf <= nf + 1'b1;
        end
      end else begin
        sf <= sf + 1'b1;
      end
    end
  end

  // Valid/last shift pipe mirroring the memory latency of each issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && beat_last;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // In-flight and FIFO occupancy plus pointers; credits freed by a pop are seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (issue && !push)      inflight <= inflight + 1'b1;
      else if (!issue && push) inflight <= inflight - 1'b1;
      if (push && !pop)        fifo_count <= fifo_count + 1'b1;
      else if (!push && pop)   fifo_count <= fifo_count - 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage; contents are only meaningful where the occupancy says so.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rd_data;
      fifo_last[wr_ptr] <= last_pipe[MEM_LATENCY-1];
    end
  end

`ifdef MVU_WEIGHT_STREAMER_PERF_EN
  // Saturating stall/starve counters, cleared on job acceptance, held after done.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_stall_cycles  <= '0;
      perf_starve_cycles <= '0;
    end else begin
      if (busy && m_axis_weights.tvalid && !m_axis_weights.tready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if ((state != IDLE) && !m_axis_weights.tvalid && (perf_starve_cycles != '1))
        perf_starve_cycles <= perf_starve_cycles + 1'b1;
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Directed bench for mvu_weight_streamer with the default 16x8 / PE2 / SIMD4 /
// latency-2 configuration; the memory model returns word i for address i.
module tb_mvu_weight_streamer;

  localparam int MEM_LATENCY = 2;
  localparam int ADDR_W      = 4;
  localparam int WW          = 32;
  localparam int WW_BA       = 32;
  localparam int BUDGET      = 2000;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       cfg_reps;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [WW-1:0]     mem_rd_data;
`ifdef MVU_WEIGHT_STREAMER_PERF_EN
  logic [31:0]       perf_stall_cycles;
  logic [31:0]       perf_starve_cycles;
`endif

  mvu_weight_streamer_if #(.DATA_W(WW_BA)) axis ();

  mvu_weight_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_reps       (cfg_reps),
    .busy           (busy),
    .done           (done),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .m_axis_weights (axis)
`ifdef MVU_WEIGHT_STREAMER_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_starve_cycles (perf_starve_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory model: word i = i, valid MEM_LATENCY cycles after the read.
  logic [ADDR_W-1:0] rd_pipe [MEM_LATENCY];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_addr;
    for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = WW'(rd_pipe[MEM_LATENCY-1]);

  int checks   = 0;
  int failures = 0;

  int beats, lasts, issued, max_out, first_valid, last_hs, done_cyc, done_cnt;
  int busy_seen, stab_err, stale, perf_stall_at_done;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Runs one job: mode 0 ready=1, mode 1 random ready, mode 2 ready=0 for stall_n cycles.
  // abort_at>0 stops after that many cycles without waiting for done.
  task automatic applyStimulus(input int reps, input int mode, input int stall_n, input int abort_at);
    logic             prev_stall;
    logic [WW_BA-1:0] prev_data;
    logic             prev_last;
    beats = 0; lasts = 0; issued = 0; max_out = 0; first_valid = -1; last_hs = -1;
    done_cyc = -1; done_cnt = 0; busy_seen = 0; stab_err = 0; perf_stall_at_done = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) || (mode == 1 && c == 10);
      cfg_reps = (c == 0) ? 16'(reps) : 16'd7;
      case (mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = 1'($urandom_range(0, 1));
        default: axis.tready = (c >= stall_n);
      endcase
      @(negedge clk);
      if (axis.tvalid && first_valid < 0) first_valid = c;
      if (busy) busy_seen = 1;
      if (prev_stall && (!axis.tvalid || axis.tdata !== prev_data || axis.tlast !== prev_last))
        stab_err++;
      if (mem_rd_en) begin
        checkOutput("rd_addr", mem_rd_addr, issued % 16);
        issued++;
      end
      if (axis.tvalid && axis.tready) begin
        checkOutput("tdata", axis.tdata, beats % 16);
        checkOutput("tlast", axis.tlast, (beats % 16) == 15);
        if (axis.tlast) lasts++;
        beats++;
        last_hs = c;
      end
      if (issued - beats > max_out) max_out = issued - beats;
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      if (done) begin
        done_cnt++;
        done_cyc = c;
`ifdef MVU_WEIGHT_STREAMER_PERF_EN
        perf_stall_at_done = int'(perf_stall_cycles);
`endif
      end
      if (abort_at > 0 && c == abort_at - 1) break;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_reps = '0; axis.tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_rd_addr", mem_rd_addr, 0);
    checkOutput("rst_tvalid", axis.tvalid, 0);
    checkOutput("rst_tlast", axis.tlast, 0);
    checkOutput("rst_tdata", axis.tdata, 0);
    @(posedge clk); #1; rst = 1'b0;

    $display("[TB] single image, tready=1");
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1_beats", beats, 16);
    checkOutput("t1_lasts", lasts, 1);
    checkOutput("t1_first_valid", first_valid, 4);
    checkOutput("t1_no_bubbles", last_hs - first_valid, 15);
    checkOutput("t1_done_lat", done_cyc - last_hs, 1);
    checkOutput("t1_done_cnt", done_cnt, 1);
    checkOutput("t1_credit", max_out <= 4, 1);

    $display("[TB] three images, random tready, start while busy");
    applyStimulus(3, 1, 0, 0);
    checkOutput("t2_beats", beats, 48);
    checkOutput("t2_lasts", lasts, 3);
    checkOutput("t2_stable", stab_err, 0);
    checkOutput("t2_done_lat", done_cyc - last_hs, 1);
    checkOutput("t2_done_cnt", done_cnt, 1);
    checkOutput("t2_credit", max_out <= 4, 1);

    $display("[TB] tready low for 20 cycles");
    applyStimulus(1, 2, 20, 0);
    checkOutput("t3_max_out", max_out, 4);
    checkOutput("t3_beats", beats, 16);
    checkOutput("t3_stable", stab_err, 0);
    checkOutput("t3_done_cnt", done_cnt, 1);

    $display("[TB] zero images");
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_done_cyc", done_cyc, 1);
    checkOutput("t4_done_cnt", done_cnt, 1);
    checkOutput("t4_busy_seen", busy_seen, 0);
    checkOutput("t4_issued", issued, 0);

    $display("[TB] reset mid-job then fresh job");
    applyStimulus(2, 0, 0, 5);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_tvalid", axis.tvalid, 0);
    checkOutput("t5_rd_en", mem_rd_en, 0);
    stale = 0; done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (axis.tvalid) stale++;
      if (done) done_cnt++;
    end
    checkOutput("t5_stale", stale, 0);
    checkOutput("t5_no_done", done_cnt, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_beats", beats, 16);
    checkOutput("t5_lasts", lasts, 1);
    checkOutput("t5_done_cnt", done_cnt, 1);

`ifdef MVU_WEIGHT_STREAMER_PERF_EN
    $display("[TB] perf stall counter");
    applyStimulus(1, 2, 14, 0);
    checkOutput("perf_stall", perf_stall_at_done, 10);
    checkOutput("perf_beats", beats, 16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
